fd_pipe_reg: RTL and testbench
==============================

FD_PIPE_REG -- requirements
Module: fd_pipe_reg

Interface
REQ-001 SHALL have port clk  in  1  single rising-edge clock.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port F_stall  in  1  hold F register (predicted PC).
REQ-004 SHALL have port D_stall  in  1  hold D register (from hazard control).
REQ-005 SHALL have port D_bubble  in  1  load NOP into D register (from hazard control).
REQ-006 SHALL have port f_predPC  in  64  next predicted PC from fetch logic.
REQ-007 SHALL have ports f_icode, f_ifun, f_rA, f_rB  in  4 each  fetched instruction fields.
REQ-008 SHALL have ports f_valC, f_valP  in  64 each  constant word and incremented PC.
REQ-009 SHALL have port f_stat  in  2  fetch status: AOK=0, HLT=1, ADR=2, INS=3.
REQ-010 SHALL have port F_predPC  out  64  registered predicted PC.
REQ-011 SHALL have ports D_icode, D_ifun, D_rA, D_rB  out  4 each  registered fields for decode.
REQ-012 SHALL have ports D_valC, D_valP  out  64 each; D_stat  out  2.
REQ-013 SHALL have ports stall_cnt, bubble_cnt  out  32 each  performance counters.

Function
REQ-014 F register SHALL load f_predPC on every clk edge where F_stall=0, and hold when F_stall=1.
REQ-015 D register SHALL, per clk edge, apply priority: D_stall=1 -> hold all D outputs; else D_bubble=1 -> load NOP; else load f_* inputs.
REQ-016 NOP bundle SHALL be: icode=4'h1, ifun=0, rA=rB=4'hF, valC=0, valP=0, stat=AOK.
REQ-017 With D_stall=1 and D_bubble=1 in the same cycle, the stall SHALL win and the D register SHALL hold.
REQ-018 Latency SHALL be exactly one cycle from f_* inputs to D_* outputs; outputs SHALL be pure register outputs with no combinational path from any input.
REQ-019 F_stall and D_stall SHALL act independently; F_stall=1 with D_stall=0 SHALL still advance D.
REQ-020 stall_cnt SHALL increment on each edge where D_stall=1; bubble_cnt SHALL increment on each edge where D_bubble=1 and D_stall=0.
REQ-021 Both counters SHALL saturate at 32'hFFFF_FFFF and SHALL NOT wrap.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force F_predPC=0, the D register to the NOP bundle, and both counters to 0.
REQ-023 rst asserted mid-stall or mid-bubble SHALL override all control; after rst deasserts, the first clk edge SHALL obey REQ-014/015.

Configuration
REQ-024 Macro FD_PERF_CNT_EN SHALL gate the counters: defined -> REQ-020/021 behaviour; undefined -> stall_cnt and bubble_cnt SHALL be tied to constant 0, no counter flops SHALL be inferred, and the ports SHALL be retained.

Structure
REQ-025 Package pipe_pkg SHALL hold the icode constants (NOP=4'h1, HALT=4'h0, RET=4'h9, JXX=4'h7, MRMOVQ=4'h5, POPQ=4'hB), the RNONE=4'hF constant, the stat code typedef, and the NOP bundle constant.
REQ-026 The block SHALL instantiate one generic sub-module, pipe_reg (parameter WIDTH, RESET_VAL; ports clk, rst, stall, bubble, bubble_val, d, q), once for F (bubble tied 0) and once for D.

Verification
REQ-027 Reset: drive rst=1 mid-cycle -> F_predPC=0, D_icode=4'h1, D_rA=4'hF, D_stat=AOK and counters=0 before the next clk edge.
REQ-028 Normal flow: f_icode=4'h6, f_valP=64'h12, f_predPC=64'h12 with no stall or bubble -> D_icode=4'h6, D_valP=64'h12 and F_predPC=64'h12 after 1 edge.
REQ-029 Load-use: D_stall=1 and F_stall=1 for 1 cycle while f_icode changes 6->2 -> D_icode stays 6 and F_predPC is unchanged; stall_cnt=1.
REQ-030 Ret bubble: D_bubble=1 for 3 cycles -> D_icode=4'h1 for 3 cycles; bubble_cnt=3.
REQ-031 Simultaneous: D_stall=1 and D_bubble=1 -> D holds its previous values; stall_cnt increments and bubble_cnt does not.
REQ-032 Saturation: with FD_PERF_CNT_EN, force stall_cnt to 32'hFFFF_FFFE and apply 3 stalls -> stall_cnt=32'hFFFF_FFFF; without the macro -> counters read 0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared constants and types for the fetch/decode pipeline registers.
//   icode constants   : I_HALT, I_NOP, I_MRMOVQ, I_JXX, I_RET, I_POPQ
//   register constant : RNONE (no register operand)
//   stat_t            : fetch status code (AOK/HLT/ADR/INS)
//   d_bundle_t        : packed contents of the D pipeline register
//   NOP_BUNDLE        : value loaded into D on reset or bubble
//   CNT_MAX           : saturation value of the performance counters
package pipe_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    stat_t       stat;
  } d_bundle_t;

  localparam int D_WIDTH = $bits(d_bundle_t);

  localparam d_bundle_t NOP_BUNDLE = '{
    icode: I_NOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  64'h0,
    valp:  64'h0,
    stat:  STAT_AOK
  };

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_reg.sv
// pipe_reg -- generic pipeline register with stall (hold) and bubble (load constant).
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, loads RESET_VAL
//   stall      : hold current value; has priority over bubble
//   bubble     : load bubble_val instead of d
//   bubble_val : value injected on a bubble
//   d / q      : data in / registered data out
module pipe_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [WIDTH-1:0] bubble_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (stall) begin
      q <= q;
    end else if (bubble) begin
      q <= bubble_val;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg -- F (predicted PC) and D (fetched instruction) pipeline registers
// with stall/bubble control and optional stall/bubble performance counters.
//   clk, rst                : clock, asynchronous active-high reset
//   F_stall                 : hold F register
//   D_stall, D_bubble       : hold D / inject NOP into D (stall wins)
//   f_predPC, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat : fetch outputs
//   F_predPC                : registered predicted PC
//   D_icode .. D_stat       : registered decode-stage fields
//   stall_cnt, bubble_cnt   : saturating performance counters
// Configuration: define FD_PERF_CNT_EN to build the counters; otherwise both
// counter outputs are constant zero and no counter flops exist.
module fd_pipe_reg
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [63:0] f_predPC,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [1:0]  f_stat,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [1:0]  D_stat,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  d_bundle_t d_in;
  d_bundle_t d_q;

  assign d_in = '{
    icode: f_icode,
    ifun:  f_ifun,
    ra:    f_rA,
    rb:    f_rB,
    valc:  f_valC,
    valp:  f_valP,
    stat:  stat_t'(f_stat)
  };

  // F never bubbles; only its stall input is live.
  pipe_reg #(
    .WIDTH     (64),
    .RESET_VAL (64'h0)
  ) u_f_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (F_stall),
    .bubble     (1'b0),
    .bubble_val (64'h0),
    .d          (f_predPC),
    .q          (F_predPC)
  );

  pipe_reg #(
    .WIDTH     (D_WIDTH),
    .RESET_VAL (NOP_BUNDLE)
  ) u_d_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (D_stall),
    .bubble     (D_bubble),
    .bubble_val (NOP_BUNDLE),
    .d          (d_in),
    .q          (d_q)
  );

  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;
  assign D_stat  = d_q.stat;

`ifdef FD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  // A bubble that coincides with a stall is not applied, so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= 32'h0;
      bubble_q <= 32'h0;
    end else begin
      if (D_stall && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 32'h1;
      end
      if (D_bubble && !D_stall && (bubble_q != CNT_MAX)) begin
        bubble_q <= bubble_q + 32'h1;
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// tb_fd_pipe_reg -- directed bench for fd_pipe_reg.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_fd_pipe_reg;

  logic        clk;
  logic        rst;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic [63:0] f_predPC;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [1:0]  f_stat;
  logic [63:0] F_predPC;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;
  logic [1:0]  D_stat;
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

`ifdef FD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // expected counter model
  logic [31:0] exp_stall;
  logic [31:0] exp_bubble;

  fd_pipe_reg dut (
    .clk        (clk),
    .rst        (rst),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .f_predPC   (f_predPC),
    .f_icode    (f_icode),
    .f_ifun     (f_ifun),
    .f_rA       (f_rA),
    .f_rB       (f_rB),
    .f_valC     (f_valC),
    .f_valP     (f_valP),
    .f_stat     (f_stat),
    .F_predPC   (F_predPC),
    .D_icode    (D_icode),
    .D_ifun     (D_ifun),
    .D_rA       (D_rA),
    .D_rB       (D_rB),
    .D_valC     (D_valC),
    .D_valP     (D_valP),
    .D_stat     (D_stat),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, updating the counter model with the controls in force
  task automatic step();
    if (PERF) begin
      if (D_stall && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'h1;
      if (D_bubble && !D_stall && exp_bubble != 32'hFFFF_FFFF) exp_bubble = exp_bubble + 32'h1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic [3:0] icode, input logic [63:0] valp, input logic [63:0] pc);
    f_icode  = icode;
    f_ifun   = 4'h0;
    f_rA     = 4'h2;
    f_rB     = 4'h3;
    f_valC   = 64'hAB;
    f_valP   = valp;
    f_predPC = pc;
    f_stat   = 2'd0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stall_cnt"}, {32'h0, stall_cnt}, {32'h0, exp_stall});
    chk({tag, "_bubble_cnt"}, {32'h0, bubble_cnt}, {32'h0, exp_bubble});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_F_predPC"}, F_predPC, 64'h0);
    chk({tag, "_D_icode"}, {60'h0, D_icode}, 64'h1);
    chk({tag, "_D_ifun"}, {60'h0, D_ifun}, 64'h0);
    chk({tag, "_D_rA"}, {60'h0, D_rA}, 64'hF);
    chk({tag, "_D_rB"}, {60'h0, D_rB}, 64'hF);
    chk({tag, "_D_valC"}, D_valC, 64'h0);
    chk({tag, "_D_valP"}, D_valP, 64'h0);
    chk({tag, "_D_stat"}, {62'h0, D_stat}, 64'h0);
    chk_cnt(tag);
  endtask

  initial begin
    exp_stall  = 32'h0;
    exp_bubble = 32'h0;
    rst      = 1'b0;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    drive_f(4'h0, 64'h0, 64'h0);

    // reset asserted mid-cycle, checked before any clock edge
    #2 rst = 1'b1;
    #1 chk_reset_vals("reset_async");
    step();
    #2 rst = 1'b0;

    // normal flow, plus one-cycle latency (no change before the edge)
    drive_f(4'h6, 64'h12, 64'h12);
    #1 chk("latency_D_icode_before_edge", {60'h0, D_icode}, 64'h1);
    step();
    chk("normal_D_icode", {60'h0, D_icode}, 64'h6);
    chk("normal_D_valP", D_valP, 64'h12);
    chk("normal_D_valC", D_valC, 64'hAB);
    chk("normal_D_rA", {60'h0, D_rA}, 64'h2);
    chk("normal_F_predPC", F_predPC, 64'h12);

    // load-use stall of both registers
    F_stall = 1'b1;
    D_stall = 1'b1;
    drive_f(4'h2, 64'h14, 64'h14);
    step();
    chk("loaduse_D_icode", {60'h0, D_icode}, 64'h6);
    chk("loaduse_D_valP", D_valP, 64'h12);
    chk("loaduse_F_predPC", F_predPC, 64'h12);
    chk_cnt("loaduse");

    // release the stall: the waiting instruction advances
    F_stall = 1'b0;
    D_stall = 1'b0;
    step();
    chk("release_D_icode", {60'h0, D_icode}, 64'h2);
    chk("release_F_predPC", F_predPC, 64'h14);

    // F stalled alone: D still advances
    F_stall = 1'b1;
    drive_f(4'h3, 64'h20, 64'h20);
    step();
    chk("fonly_D_icode", {60'h0, D_icode}, 64'h3);
    chk("fonly_D_valP", D_valP, 64'h20);
    chk("fonly_F_predPC", F_predPC, 64'h14);
    F_stall = 1'b0;

    // three ret bubbles
    D_bubble = 1'b1;
    drive_f(4'h9, 64'h28, 64'h28);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bubble%0d_D_icode", i), {60'h0, D_icode}, 64'h1);
      chk($sformatf("bubble%0d_D_rB", i), {60'h0, D_rB}, 64'hF);
      chk($sformatf("bubble%0d_D_valP", i), D_valP, 64'h0);
    end
    chk_cnt("bubble");

    // load a known instruction, then stall and bubble together: stall wins
    D_bubble = 1'b0;
    drive_f(4'h5, 64'h30, 64'h30);
    step();
    chk("preload_D_icode", {60'h0, D_icode}, 64'h5);
    D_stall  = 1'b1;
    D_bubble = 1'b1;
    drive_f(4'h7, 64'h38, 64'h38);
    step();
    chk("simul_D_icode", {60'h0, D_icode}, 64'h5);
    chk("simul_D_valP", D_valP, 64'h30);
    chk("simul_F_predPC", F_predPC, 64'h38);
    chk_cnt("simul");

    // saturation: three stalls starting from one below the maximum
    D_bubble = 1'b0;
`ifdef FD_PERF_CNT_EN
    force dut.stall_q = 32'hFFFF_FFFE;
    #1 release dut.stall_q;
    exp_stall = 32'hFFFF_FFFE;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cnt($sformatf("sat%0d", i));
    end
    chk("sat_D_icode_held", {60'h0, D_icode}, 64'h5);

    // reset mid-stall and mid-bubble overrides everything immediately
    D_bubble = 1'b1;
    #2 rst = 1'b1;
    exp_stall  = 32'h0;
    exp_bubble = 32'h0;
    #1 chk_reset_vals("reset_midstall");
    @(posedge clk);
    #2 rst = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    f_rA     = 4'h4;
    drive_f(4'hB, 64'h40, 64'h40);
    step();
    chk("postreset_D_icode", {60'h0, D_icode}, 64'hB);
    chk("postreset_F_predPC", F_predPC, 64'h40);
    chk_cnt("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
